// File: rtl/cache_controller.sv
// -----------------------------------------------------------------------------
// cache_controller
//   Direct-mapped, write-through, no-write-allocate cache sitting between the
//   CPU load/store port and a word-addressed data memory. Lines are 4 words.
//   Load misses fill the whole line one word at a time. Each memory word
//   transfer takes MEM_LATENCY cycles. Stores always go to memory, and they
//   update the cached copy only when the line is already present.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   cpu_addr        word address {tag, index, offset[1:0]}
//   cpu_wdata       store data
//   cpu_read/write  request levels (write wins if both are high)
//   cpu_rdata       load data, valid when cpu_read & !cpu_stall
//   cpu_stall       combinational; 1 while the request is not complete
//   mem_address     memory word address
//   mem_write_data  memory store data
//   mem_read_data   memory load data (combinational from mem_address)
//   mem_read        memory read enable
//   mem_write       memory write enable (single-cycle pulse)
//   access_count    completed CPU requests (wraps)
//   hit_count       completed loads that needed no fill
//
// Handshake: the CPU raises cpu_read or cpu_write with a stable address and
// data. It holds them while cpu_stall=1. The request completes in the first
// cycle in which cpu_stall=0. After that cycle the CPU must drop or change
// the request.
// -----------------------------------------------------------------------------
module cache_controller #(
    parameter int WORD        = 32,
    parameter int ADDR_W      = 15,
    parameter int INDEX_W     = 10,
    parameter int MEM_LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WORD-1:0]   cpu_wdata,
    input  logic              cpu_read,
    input  logic              cpu_write,
    output logic [WORD-1:0]   cpu_rdata,
    output logic              cpu_stall,
    output logic [ADDR_W-1:0] mem_address,
    output logic [WORD-1:0]   mem_write_data,
    input  logic [WORD-1:0]   mem_read_data,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       access_count,
    output logic [31:0]       hit_count
);
    localparam int TAG_W = ADDR_W - INDEX_W - 2;
    localparam int LINES = 1 << INDEX_W;
    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        word_q, word_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              miss_q, miss_d;
    logic [31:0]       access_q, access_d;
    logic [31:0]       hit_q, hit_d;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [WORD-1:0]   data_q [LINES*4];

    logic [TAG_W-1:0]   addr_tag;
    logic [INDEX_W-1:0] addr_index;
    logic [1:0]         addr_offset;
    logic               hit;
    logic               lat_last;
    logic               fill_we;
    logic               fill_done;
    logic               store_we;

    assign addr_tag    = cpu_addr[ADDR_W-1:INDEX_W+2];
    assign addr_index  = cpu_addr[INDEX_W+1:2];
    assign addr_offset = cpu_addr[1:0];
    assign hit         = valid_q[addr_index] && (tag_q[addr_index] == addr_tag);
    assign lat_last    = (lat_q == LAT_W'(MEM_LATENCY - 1));

    assign fill_we   = (state_q == FILL) && lat_last;
    assign fill_done = fill_we && (word_q == 2'd3);
    // A store miss leaves the cache untouched (no write-allocate).
    assign store_we  = (state_q == WRITE) && lat_last && hit;

    assign access_count = access_q;
    assign hit_count    = hit_q;

    always_comb begin
        state_d        = state_q;
        word_d         = word_q;
        lat_d          = lat_q;
        miss_d         = miss_q;
        access_d       = access_q;
        hit_d          = hit_q;
        cpu_stall      = 1'b0;
        cpu_rdata      = '0;
        mem_address    = '0;
        mem_write_data = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_write) begin
                    cpu_stall = 1'b1;
                    lat_d     = '0;
                    state_d   = WRITE;
                end else if (cpu_read) begin
                    if (hit) begin
                        cpu_rdata = data_q[{addr_index, addr_offset}];
                        access_d  = access_q + 32'd1;
                        // The hit right after a fill belongs to the miss, so it is not counted.
                        if (miss_q) miss_d = 1'b0;
                        else        hit_d  = hit_q + 32'd1;
                    end else begin
                        cpu_stall = 1'b1;
                        miss_d    = 1'b1;
                        word_d    = 2'd0;
                        lat_d     = '0;
                        state_d   = FILL;
                    end
                end
            end
            FILL: begin
                cpu_stall   = 1'b1;
                mem_read    = 1'b1;
                mem_address = {addr_tag, addr_index, word_q};
                if (lat_last) begin
                    lat_d  = '0;
                    word_d = word_q + 2'd1;
                    if (word_q == 2'd3) state_d = IDLE;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            WRITE: begin
                cpu_stall      = 1'b1;
                mem_address    = cpu_addr;
                mem_write_data = cpu_wdata;
                if (lat_last) begin
                    mem_write = 1'b1;
                    lat_d     = '0;
                    state_d   = DONE;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            DONE: begin
                access_d = access_q + 32'd1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            word_q   <= '0;
            lat_q    <= '0;
            miss_q   <= 1'b0;
            access_q <= '0;
            hit_q    <= '0;
            valid_q  <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            lat_q    <= lat_d;
            miss_q   <= miss_d;
            access_q <= access_d;
            hit_q    <= hit_d;
            // The valid bit is set only at fill completion, so an interrupted fill stays invalid.
            if (fill_done) valid_q[addr_index] <= 1'b1;
        end
    end

    // Tag and data arrays need no reset, because the valid bits guard them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (fill_we)   data_q[{addr_index, word_q}]      <= mem_read_data;
            if (fill_done) tag_q[addr_index]                 <= addr_tag;
            if (store_we)  data_q[{addr_index, addr_offset}] <= cpu_wdata;
        end
    end

endmodule
